conv_idx_counter: RTL
=====================

# conv_idx_counter

Parametrised three-level loop-index generator for the convolution datapath. It replaces fixed mod-3 kernel-column counters with cascaded kernel-column (j), kernel-row (i) and input-channel (c) counters. Their terminal values are programmed at run time, and the block adds a start/busy/done handshake, an advance enable and a synchronous abort. Address generators and MAC accumulate/flush control in each layer consume its index outputs and terminal flags.

## Interface
- J_W, 2, width of j counter and kw_max
- I_W, 2, width of i counter and kh_max
- C_W, 8, width of c counter and ch_max
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a sweep; sampled only in IDLE
- en  input  1  advance indices by one step; sampled only in RUN
- clr  input  1  synchronous abort/clear; highest priority after rst
- kw_max  input  J_W  terminal value of j (kernel width − 1); latched at start
- kh_max  input  I_W  terminal value of i (kernel height − 1); latched at start
- ch_max  input  C_W  terminal value of c (channels − 1); latched at start
- j  output  J_W  kernel-column index (registered)
- i  output  I_W  kernel-row index (registered)
- c  output  C_W  channel index (registered)
- j_term  output  1  combinational: busy && j==kw_lat
- i_term  output  1  combinational: j_term && i==kh_lat
- last  output  1  combinational: i_term && c==ch_lat
- busy  output  1  registered: state==RUN
- done  output  1  registered one-cycle pulse after the final step

## Operation
- States: IDLE, RUN.
- Reset (rst=0, asynchronous): IDLE; j, i, c, kw_lat, kh_lat, ch_lat = 0; busy=0; done=0. Terminal flags are therefore 0.
- Per clock edge, evaluated in priority order:
  1. clr=1: j, i, c ← 0; state ← IDLE; done ← 0. Latched limits hold. This applies in any state and overrides start and en.
  2. IDLE, start=1: latch kw_max, kh_max, ch_max; j, i, c ← 0; state ← RUN; done ← 0.
  3. RUN, en=1, last=0: advance the indices.
     - j ← (j==kw_lat) ? 0 : j+1.
     - i advances the same way only when j_term=1.
     - c ← c+1 only when i_term=1.
  4. RUN, en=1, last=1: j, i, c ← 0; state ← IDLE; done ← 1.
  5. Otherwise all registers hold, except done ← 0.
- start in RUN is ignored. en in IDLE is ignored. Inputs kw_max, kh_max and ch_max are don't-care except in the start cycle.
- A limit of 0 means that counter stays 0 and its level's term flag is permanently true while busy.
- A sweep takes exactly (kw_lat+1)(kh_lat+1)(ch_lat+1) enabled RUN cycles.
- Arithmetic: unsigned, natural widths. The counter never exceeds its latched limit, so no overflow wrap is reachable.
- With kw_lat=2, j follows 0,1,2,0,… and j_term marks j==2.

## Timing
- start at edge k gives busy=1, j=i=c=0 after edge k. The first advance happens at the first edge after k with en=1.
- Term flags are combinational from registers and limits; they are valid throughout a cycle and independent of en.
- For the final enabled edge f: after f, done=1, busy=0, indices 0. After f+1, done=0.
- A new start is accepted in the done cycle (state is IDLE). It yields busy=1 and done=0 after that edge.
- Stalls (en=0) freeze all indices and flags indefinitely.
- clr mid-sweep: after the edge, busy=0, indices 0, no done pulse.
- rst mid-sweep clears immediately, without waiting for a clock edge.

## Test plan
- Reset/defaults: rst low mid-sweep (j=1, i=1, c=3) → j=i=c=0, busy=0, done=0, last=0 without waiting for a clock edge.
- Classic 3×3×4 sweep, en held high: start with kw=2, kh=2, ch=3 → 36 enabled cycles.
  - j cycles 0,1,2 with j_term on j==2.
  - i_term on (i,j)=(2,2).
  - last high only at (c,i,j)=(3,2,2).
  - done pulses one cycle after that step, then busy=0.
- Stalls: same sweep with en toggling pseudo-randomly → identical index sequence, done after exactly 36 en=1 cycles, no change on en=0 cycles.
- Degenerate limits: kw=0, kh=0, ch=0 → busy one cycle at (0,0,0) with last=1; done after the first en. Also kw=0, kh=1, ch=1 → 4 steps, j_term constantly 1.
- Abort and priority:
  - clr in the same cycle as start → stays IDLE.
  - clr at step 10 of the 36 → busy=0, indices 0, no done pulse.
  - start during RUN → ignored.
  - Changing kw_max during RUN → no effect.
- Back-to-back: start asserted in the done cycle with kw=1, kh=0, ch=2 → busy=1 next cycle, 6-step sweep, second done pulse.

Source files
------------

// File: rtl/conv_idx_counter.sv
// conv_idx_counter
// ----------------
// Three-level loop-index generator for the convolution datapath. It produces
// a kernel-column index j, a kernel-row index i and an input-channel index c.
// The counters cascade: j is the fastest index and c is the slowest. Each
// counter's terminal value is latched when a sweep starts. Address generators
// and the MAC accumulate/flush control consume the indices and the terminal
// flags.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          begin a sweep (honoured only in IDLE)
//   en             advance indices one step (honoured only in RUN)
//   clr            synchronous abort; overrides start and en
//   kw_max/kh_max/ch_max  terminal values of j/i/c, latched on start
//   j, i, c        registered loop indices
//   j_term         busy and j at its terminal value
//   i_term         j_term and i at its terminal value
//   last           i_term and c at its terminal value (final step of sweep)
//   busy           registered, high while a sweep is in progress
//   done           registered one-cycle pulse after the final step
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; indices held at zero
// RUN   | sweep in progress; indices advance on each en cycle

module conv_idx_counter #(
  parameter int J_W = 2,
  parameter int I_W = 2,
  parameter int C_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           en,
  input  logic           clr,
  input  logic [J_W-1:0] kw_max,
  input  logic [I_W-1:0] kh_max,
  input  logic [C_W-1:0] ch_max,
  output logic [J_W-1:0] j,
  output logic [I_W-1:0] i,
  output logic [C_W-1:0] c,
  output logic           j_term,
  output logic           i_term,
  output logic           last,
  output logic           busy,
  output logic           done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_nxt;

  logic [J_W-1:0] kw_lat, kw_lat_nxt;
  logic [I_W-1:0] kh_lat, kh_lat_nxt;
  logic [C_W-1:0] ch_lat, ch_lat_nxt;
  logic [J_W-1:0] j_nxt;
  logic [I_W-1:0] i_nxt;
  logic [C_W-1:0] c_nxt;
  logic           done_nxt;

  // busy comes straight from the state flop, so it is a registered output.
  assign busy = (state == RUN);

  // The flags are gated by busy. A zero limit then does not leave a flag
  // stuck high while the block is idle.
  assign j_term = busy && (j == kw_lat);
  assign i_term = j_term && (i == kh_lat);
  assign last   = i_term && (c == ch_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      kw_lat <= '0;
      kh_lat <= '0;
      ch_lat <= '0;
      j      <= '0;
      i      <= '0;
      c      <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      kw_lat <= kw_lat_nxt;
      kh_lat <= kh_lat_nxt;
      ch_lat <= ch_lat_nxt;
      j      <= j_nxt;
      i      <= i_nxt;
      c      <= c_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    kw_lat_nxt = kw_lat;
    kh_lat_nxt = kh_lat;
    ch_lat_nxt = ch_lat;
    j_nxt      = j;
    i_nxt      = i;
    c_nxt      = c;
    done_nxt   = 1'b0;

    if (clr) begin
      // The abort keeps the latched limits. Only the indices and the state
      // are cleared.
      state_nxt = IDLE;
      j_nxt     = '0;
      i_nxt     = '0;
      c_nxt     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            kw_lat_nxt = kw_max;
            kh_lat_nxt = kh_max;
            ch_lat_nxt = ch_max;
            j_nxt      = '0;
            i_nxt      = '0;
            c_nxt      = '0;
            state_nxt  = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (last) begin
              j_nxt     = '0;
              i_nxt     = '0;
              c_nxt     = '0;
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              j_nxt = j_term ? '0 : j + J_W'(1);
              if (j_term) begin
                i_nxt = i_term ? '0 : i + I_W'(1);
              end
              // c never wraps here. Reaching its limit with i_term set is
              // the last case, which is handled above.
              if (i_term) begin
                c_nxt = c + C_W'(1);
              end
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
